// File: rtl/bin_a_bcd_pkg.sv
// Shared types and constants for the bin_a_bcd converter.
// State enum, default sizes and the counter-width helper.
package bin_a_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } estado_t;

  localparam int ANCHO_DEF   = 32;
  localparam int DIGITOS_DEF = 10;

  function automatic int cnt_ancho(input int ancho);
    return $clog2(ancho + 1);
  endfunction

  // 10**d > 2**n  <=>  d*log2(10) > n
  function automatic bit cabe(input int n, input int d);
    return (longint'(d) * 64'd3321928) > (longint'(n) * 64'd1000000);
  endfunction

endpackage

// File: rtl/bin_a_bcd_digito.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
// Purely combinational; the carry out of the nibble is discarded.
module digito_ajuste
  import bin_a_bcd_pkg::*;
(
  input  logic [3:0] dig,
  output logic [3:0] aj
);

  assign aj = (dig >= 4'd5) ? dig + 4'd3 : dig;

endmodule

// File: rtl/bin_a_bcd.sv
// Sequential shift-add-3 binary to packed BCD converter.
// One input bit per clock, valid/ready on both sides.
module bin_a_bcd
  import bin_a_bcd_pkg::*;
#(
  parameter int ANCHO_IN = ANCHO_DEF,
  parameter int DIGITOS  = DIGITOS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valido,
  output logic                   in_listo,
  input  logic [ANCHO_IN-1:0]    in_dato,
  output logic                   out_valido,
  input  logic                   out_listo,
  output logic [4*DIGITOS-1:0]   out_bcd,
  output logic                   ocupado
);

  localparam int CW = cnt_ancho(ANCHO_IN);
  localparam int BW = 4 * DIGITOS;

  if (!cabe(ANCHO_IN, DIGITOS)) begin : g_chk
    $error("bin_a_bcd: DIGITOS too small for ANCHO_IN");
  end

  estado_t             estado, estado_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [ANCHO_IN-1:0] bin, bin_n;
  logic [BW-1:0]       bcd, bcd_n;
  logic [BW-1:0]       bcd_aj;
  logic [BW-1:0]       out_bcd_n;
  logic                out_valido_n;

  for (genvar i = 0; i < DIGITOS; i++) begin : g_dig
    digito_ajuste u_aj (
      .dig (bcd[4*i +: 4]),
      .aj  (bcd_aj[4*i +: 4])
    );
  end

  assign in_listo = (estado == IDLE);
  assign ocupado  = (estado != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= IDLE;
      cnt        <= '0;
      bin        <= '0;
      bcd        <= '0;
      out_bcd    <= '0;
      out_valido <= 1'b0;
    end else begin
      estado     <= estado_n;
      cnt        <= cnt_n;
      bin        <= bin_n;
      bcd        <= bcd_n;
      out_bcd    <= out_bcd_n;
      out_valido <= out_valido_n;
    end
  end

  always_comb begin
    estado_n     = estado;
    cnt_n        = cnt;
    bin_n        = bin;
    bcd_n        = bcd;
    out_bcd_n    = out_bcd;
    out_valido_n = out_valido;
    unique case (1'b1)
      (estado == IDLE): begin
        if (in_valido) begin
          bin_n    = in_dato;
          bcd_n    = '0;
          cnt_n    = CW'(ANCHO_IN);
          estado_n = SHIFT;
        end
      end
      (estado == SHIFT): begin
        {bcd_n, bin_n} = {bcd_aj[BW-2:0], bin, 1'b0};
        cnt_n = cnt - CW'(1);
        // last bit: publish the finished digits straight from the shifter
        if (cnt == CW'(1)) begin
          out_bcd_n    = {bcd_aj[BW-2:0], bin[ANCHO_IN-1]};
          out_valido_n = 1'b1;
          estado_n     = DONE;
        end
      end
      (estado == DONE): begin
        if (out_listo) begin
          out_valido_n = 1'b0;
          estado_n     = IDLE;
        end
      end
      default: estado_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin_a_bcd.sv
// Randomized self-checking bench for bin_a_bcd.
// Reference digits come from repeated division by ten.
module tb_bin_a_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valido = 1'b0;
  logic        in_listo;
  logic [31:0] in_dato = '0;
  logic        out_valido;
  logic        out_listo = 1'b0;
  logic [39:0] out_bcd;
  logic        ocupado;

  int errs = 0;
  int checks = 0;

  bin_a_bcd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valido  (in_valido),
    .in_listo   (in_listo),
    .in_dato    (in_dato),
    .out_valido (out_valido),
    .out_listo  (out_listo),
    .out_bcd    (out_bcd),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ref_bcd(input logic [31:0] v);
    logic [39:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic convert(input logic [31:0] v, input int hold);
    logic [39:0] exp;
    logic [39:0] snap;
    int n;
    exp = ref_bcd(v);
    @(negedge clk);
    in_valido = 1'b1;
    in_dato   = v;
    out_listo = 1'b0;
    @(negedge clk);
    chk("busy", ocupado, 1);
    chk("rdy_lo", in_listo, 0);
    n = 0;
    while (!out_valido && n < 100) begin
      in_valido = 1'($urandom_range(0, 1));
      in_dato   = $urandom;
      out_listo = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd32);
    chk("bcd", out_bcd, exp);
    snap = out_bcd;
    repeat (hold) begin
      out_listo = 1'b0;
      in_valido = 1'b1;
      in_dato   = $urandom;
      @(negedge clk);
      chk("hold_bcd", out_bcd, snap);
      chk("hold_vld", out_valido, 1);
    end
    in_valido = 1'b0;
    out_listo = 1'b1;
    @(negedge clk);
    out_listo = 1'b0;
    chk("vld_drop", out_valido, 0);
    chk("rdy_back", in_listo, 1);
  endtask

  logic [31:0] vals [3];
  int outs [$];
  int seen;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", in_listo, 1);
    chk("rst_vld", out_valido, 0);
    chk("rst_busy", ocupado, 0);
    chk("rst_bcd", out_bcd, 0);

    convert(32'd0, 0);
    convert(32'd120, 0);
    convert(32'd55, 5);
    convert(32'd479001600, 0);
    convert(32'hFFFF_FFFF, 2);
    for (int i = 0; i < 12; i++)
      convert($urandom, int'($urandom_range(0, 4)));

    // abort mid-conversion
    @(negedge clk);
    in_valido = 1'b1;
    in_dato   = 32'd720;
    @(negedge clk);
    in_valido = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", ocupado, 0);
    chk("abort_vld", out_valido, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rdy", in_listo, 1);
    seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (out_valido) seen++;
    end
    chk("abort_nopulse", 64'(seen), 0);
    convert(32'd24, 0);

    // back-to-back: in_valido held, out_listo held
    vals[0] = $urandom;
    vals[1] = 32'd3628800;
    vals[2] = $urandom;
    out_listo = 1'b1;
    for (int c = 0; c < 112; c++) begin
      if (c < 102) begin
        in_valido = 1'b1;
        in_dato   = vals[c / 34];
      end else begin
        in_valido = 1'b0;
      end
      @(negedge clk);
      if (out_valido) begin
        if (outs.size() < 3)
          chk("b2b_bcd", out_bcd, ref_bcd(vals[outs.size()]));
        outs.push_back(c);
      end
    end
    out_listo = 1'b0;
    chk("b2b_count", 64'(outs.size()), 3);
    if (outs.size() == 3) begin
      chk("b2b_first", 64'(outs[0]), 64'd32);
      chk("b2b_gap1", 64'(outs[1] - outs[0]), 64'd34);
      chk("b2b_gap2", 64'(outs[2] - outs[1]), 64'd34);
    end
    chk("b2b_idle", in_listo, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
